// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a five-stage pipeline. Holds the program counter
// (a word index into a D-word instruction memory), presents it on pc_o to a
// combinational instruction memory, and captures the returned instruction
// into the IF/ID pipeline register together with PC+1 and a valid flag.
//
// Priority on each rising edge:
//   1. branch_taken_i : redirect PC, flush IF/ID to a bubble (even if stalled)
//   2. stall_i        : hold PC, IF/ID and the instruction counter
//   3. jump in IF     : redirect PC to the jump target, keep the jump in IF/ID
//   4. otherwise      : sequential fetch
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   pc_o               word address to instruction memory (upper bits zero)
//   instr_i            instruction returned combinationally for pc_o
//   stall_i            hazard-unit stall
//   branch_taken_i     resolved taken branch from a later stage
//   branch_target_i    word target of that branch
//   if_id_instr_o      IF/ID instruction (NOP when a bubble)
//   if_id_pc1_o        IF/ID PC+1 (wrapped modulo D)
//   if_id_valid_o      1 = real instruction, 0 = bubble
//   instr_count_o      count of valid instructions written into IF/ID
//
// D must be a power of two and at least 2; N must exceed log2(D).
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int              N   = 32,
  parameter int              D   = 32,
  parameter logic [N-1:0]    NOP = 32'h1000_0000
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] pc_o,
  input  logic [N-1:0] instr_i,
  input  logic         stall_i,
  input  logic         branch_taken_i,
  input  logic [N-1:0] branch_target_i,
  output logic [N-1:0] if_id_instr_o,
  output logic [N-1:0] if_id_pc1_o,
  output logic         if_id_valid_o,
  output logic [15:0]  instr_count_o
);

  localparam int         AW      = $clog2(D);
  localparam logic [5:0] JUMP_OP = 6'b000011;

  logic [AW-1:0] pc_q, pc_d;
  logic [N-1:0]  instr_q, instr_d;
  logic [N-1:0]  pc1_q, pc1_d;
  logic          valid_q, valid_d;
  logic [15:0]   count_q, count_d;

  logic [AW-1:0] pc_plus1_s;
  logic [AW-1:0] jump_target_s;
  logic [AW-1:0] branch_target_s;
  logic          is_jump_s;
  logic          unused_s;

  // Targets are word indices; keeping only the low AW bits is the mod-D reduction.
  assign pc_plus1_s      = pc_q + 1'b1;
  assign jump_target_s   = instr_i[AW-1:0];
  assign branch_target_s = branch_target_i[AW-1:0];
  assign is_jump_s       = (instr_i[N-1:N-6] == JUMP_OP);
  assign unused_s        = ^branch_target_i[N-1:AW];

  // Next-state selection for PC, IF/ID and the delivered-instruction counter.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    count_d = count_q;
    if (branch_taken_i) begin
      // A taken branch overrides a stall and discards whatever is in IF.
      pc_d    = branch_target_s;
      instr_d = NOP;
      pc1_d   = {N{1'b0}};
      valid_d = 1'b0;
    end else if (stall_i) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc1_d   = pc1_q;
      valid_d = valid_q;
    end else begin
      // The jump itself is delivered; no bubble follows it.
      if (is_jump_s) begin
        pc_d = jump_target_s;
      end else begin
        pc_d = pc_plus1_s;
      end
      instr_d = instr_i;
      pc1_d   = {{(N-AW){1'b0}}, pc_plus1_s};
      valid_d = 1'b1;
      count_d = count_q + 16'd1;
    end
  end

  // State registers with asynchronous reset to the idle/bubble values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= {AW{1'b0}};
      instr_q <= NOP;
      pc1_q   <= {N{1'b0}};
      valid_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign pc_o          = {{(N-AW){1'b0}}, pc_q};
  assign if_id_instr_o = instr_q;
  assign if_id_pc1_o   = pc1_q;
  assign if_id_valid_o = valid_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Scoreboard bench for fetch_stage. The stimulus process drives inputs on the
// falling edge and pushes the hand-computed state expected after the next
// rising edge; the monitor pops one entry shortly after every rising edge
// (or after an explicit mid-cycle reset check) and compares all outputs.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h1000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc1;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc1_o;
  logic        if_id_valid_o;
  logic [15:0] instr_count_o;

  logic [31:0] mem [32];
  exp_t        sb [$];
  logic        chk_ev;
  int          vectors;
  int          miscompares;

  fetch_stage #(.N(32), .D(32), .NOP(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_o            (pc_o),
    .instr_i         (instr_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_pc1_o     (if_id_pc1_o),
    .if_id_valid_o   (if_id_valid_o),
    .instr_count_o   (instr_count_o)
  );

  // Combinational instruction memory
  assign instr_i = mem[pc_o[4:0]];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (vector %0d): got %h expected %h", nm, vectors, act, exp);
    end
  endtask

  // Monitor: one expected entry per rising edge or reset-check event
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge chk_ev);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        chk("pc_o",          pc_o,                    e.pc);
        chk("if_id_instr_o", if_id_instr_o,           e.instr);
        chk("if_id_pc1_o",   if_id_pc1_o,             e.pc1);
        chk("if_id_valid_o", {31'd0, if_id_valid_o},  {31'd0, e.valid});
        chk("instr_count_o", {16'd0, instr_count_o},  {16'd0, e.cnt});
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] pc1, input logic v, input logic [15:0] cnt);
    exp_t e;
    e.pc = pc; e.instr = ins; e.pc1 = pc1; e.valid = v; e.cnt = cnt;
    return e;
  endfunction

  // One clock: drive inputs, expect state after the next rising edge
  task automatic cyc(input logic st, input logic br, input logic [31:0] tgt,
                     input logic [31:0] pc, input logic [31:0] ins,
                     input logic [31:0] pc1, input logic v, input logic [15:0] cnt);
    @(negedge clk);
    stall_i         = st;
    branch_taken_i  = br;
    branch_target_i = tgt;
    sb.push_back(mk(pc, ins, pc1, v, cnt));
  endtask

  // Reset pulse between edges: reset values checked before the next edge,
  // then the first post-reset edge fetches memory[0]
  task automatic do_reset();
    @(negedge clk);
    stall_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'd0;
    #1 rst = 1'b1;
    #1 sb.push_back(mk(32'd0, NOP, 32'd0, 1'b0, 16'd0));
    chk_ev = 1'b1;
    #1 chk_ev = 1'b0;
    #3 rst = 1'b0;
    sb.push_back(mk(32'd1, mem[0], 32'd1, 1'b1, 16'd1));
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    chk_ev          = 1'b0;
    rst             = 1'b1;
    stall_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h2000_0000 | i;
    mem[0]  = 32'h8C01_0004;   // lw
    mem[1]  = 32'h0022_1820;   // add
    mem[12] = 32'h0C00_0002;   // j 2
    mem[20] = 32'h0C00_0025;   // j 37 -> 5 mod 32

    // Reset, then free run
    do_reset();
    cyc(1'b0, 1'b0, 32'd0,  32'd2,  mem[1], 32'd2, 1'b1, 16'd2);
    cyc(1'b0, 1'b0, 32'd0,  32'd3,  mem[2], 32'd3, 1'b1, 16'd3);
    cyc(1'b0, 1'b0, 32'd0,  32'd4,  mem[3], 32'd4, 1'b1, 16'd4);
    cyc(1'b0, 1'b0, 32'd0,  32'd5,  mem[4], 32'd5, 1'b1, 16'd5);
    // Two-edge stall at pc 5, then release
    cyc(1'b1, 1'b0, 32'd0,  32'd5,  mem[4], 32'd5, 1'b1, 16'd5);
    cyc(1'b1, 1'b0, 32'd0,  32'd5,  mem[4], 32'd5, 1'b1, 16'd5);
    cyc(1'b0, 1'b0, 32'd0,  32'd6,  mem[5], 32'd6, 1'b1, 16'd6);
    cyc(1'b0, 1'b0, 32'd0,  32'd7,  mem[6], 32'd7, 1'b1, 16'd7);
    cyc(1'b0, 1'b0, 32'd0,  32'd8,  mem[7], 32'd8, 1'b1, 16'd8);
    // Branch with stall in the same cycle
    cyc(1'b1, 1'b1, 32'd3,  32'd3,  NOP,    32'd0, 1'b0, 16'd8);
    // Branch to the jump at 12, then the jump itself
    cyc(1'b0, 1'b1, 32'd12, 32'd12, NOP,    32'd0, 1'b0, 16'd8);
    cyc(1'b0, 1'b0, 32'd0,  32'd2,  32'h0C00_0002, 32'd13, 1'b1, 16'd9);
    cyc(1'b0, 1'b0, 32'd0,  32'd3,  mem[2], 32'd3, 1'b1, 16'd10);
    // Jump held by stall, then discarded by a branch
    cyc(1'b0, 1'b1, 32'd12, 32'd12, NOP,    32'd0, 1'b0, 16'd10);
    cyc(1'b1, 1'b0, 32'd0,  32'd12, NOP,    32'd0, 1'b0, 16'd10);
    cyc(1'b0, 1'b1, 32'd31, 32'd31, NOP,    32'd0, 1'b0, 16'd10);
    // Wrap-around from 31
    cyc(1'b0, 1'b0, 32'd0,  32'd0,  mem[31], 32'd0, 1'b1, 16'd11);
    cyc(1'b0, 1'b0, 32'd0,  32'd1,  mem[0],  32'd1, 1'b1, 16'd12);
    // Out-of-range branch target reduced mod 32
    cyc(1'b0, 1'b1, 32'd35, 32'd3,  NOP,    32'd0, 1'b0, 16'd12);
    cyc(1'b0, 1'b0, 32'd0,  32'd4,  mem[3], 32'd4, 1'b1, 16'd13);
    cyc(1'b0, 1'b0, 32'd0,  32'd5,  mem[4], 32'd5, 1'b1, 16'd14);
    // Asynchronous reset mid-run
    do_reset();
    cyc(1'b0, 1'b0, 32'd0,  32'd2,  mem[1], 32'd2, 1'b1, 16'd2);
    // Jump with a target beyond D
    cyc(1'b0, 1'b1, 32'd20, 32'd20, NOP,    32'd0, 1'b0, 16'd2);
    cyc(1'b0, 1'b0, 32'd0,  32'd5,  mem[20], 32'd21, 1'b1, 16'd3);
    cyc(1'b0, 1'b0, 32'd0,  32'd6,  mem[5], 32'd6, 1'b1, 16'd4);

    @(negedge clk);
    stall_i        = 1'b0;
    branch_taken_i = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
